// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline constants: register file geometry and the
// operand forward-select encoding used by the ID-stage operand muxes.
package mips_pkg;

  localparam int NREG = 32;
  localparam int RW   = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef logic [1:0] age_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard cell: tracks the age (0 idle, 1 EX, 2 MEM, 3 WB) of the
// newest in-flight writer of one register and whether that writer is a load.
// Ports: clk, tick (age step), set/set_ld (new writer), clr_rst (sync clear),
// age/ld (state).
module sb_entry (
  input  logic       clk,
  input  logic       tick,
  input  logic       set,
  input  logic       set_ld,
  input  logic       clr_rst,
  output logic [1:0] age,
  output logic       ld
);

  import mips_pkg::*;

  always_ff @(posedge clk) begin
    if (clr_rst) begin
      age <= 2'd0;
      ld  <= 1'b0;
    end else if (set) begin
      // newest writer replaces whatever older entry was aging here
      age <= 2'd1;
      ld  <= set_ld;
    end else if (tick && age != 2'd0) begin
      // 3 wraps to 0: the WB forward covered the write cycle
      age <= age + 2'd1;
      if (age == 2'd3)
        ld <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage register scoreboard: in-flight writer tracking, operand forward
// selects and load-use stall.
// Ports: clk, reset (sync, active-high), ID decode fields in,
// stall/issue/fwd_rs/fwd_rt out.
module reg_scoreboard #(
  parameter int NREG = mips_pkg::NREG,
  parameter int RW   = mips_pkg::RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic          id_flush,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  output logic          stall,
  output logic [1:0]    fwd_rs,
  output logic [1:0]    fwd_rt,
  output logic          issue
);

  import mips_pkg::*;

  age_t age [NREG];
  logic ld  [NREG];

  logic run;
  logic rd_rs;
  logic rd_rt;
  logic hz_rs;
  logic hz_rt;
  logic wr_en;
  age_t age_rs;
  age_t age_rt;

  // register 0 is hardwired: never tracked
  assign age[0] = 2'd0;
  assign ld[0]  = 1'b0;

  genvar r;
  for (r = 1; r < NREG; r++) begin : g_ent
    sb_entry u_ent (
      .clk     (clk),
      .tick    (1'b1),
      .set     (wr_en && id_rd == RW'(r)),
      .set_ld  (id_memread),
      .clr_rst (reset),
      .age     (age[r]),
      .ld      (ld[r])
    );
  end

  // all outputs held quiet while reset is asserted
  assign run    = ~reset;
  assign age_rs = age[id_rs];
  assign age_rt = age[id_rt];

  assign rd_rs = id_use_rs && id_rs != '0;
  assign rd_rt = id_use_rt && id_rt != '0;

  // only a load still in EX cannot be forwarded
  assign hz_rs = rd_rs && age_rs == 2'd1 && ld[id_rs];
  assign hz_rt = rd_rt && age_rt == 2'd1 && ld[id_rt];

  assign stall = run && id_valid && !id_flush && (hz_rs || hz_rt);
  assign issue = run && id_valid && !id_flush && !stall;
  assign wr_en = issue && id_regwrite && id_rd != '0;

  // age value doubles as the forward select (1 EX, 2 MEM, 3 WB)
  assign fwd_rs = (run && rd_rs) ? age_rs : FWD_RF;
  assign fwd_rt = (run && rd_rt) ? age_rt : FWD_RF;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// Drives one ID instruction per cycle and checks stall/issue/forward selects.
module tb_reg_scoreboard;

  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic       id_flush;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       stall;
  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       issue;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_flush    (id_flush),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .stall       (stall),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt),
    .issue       (issue)
  );

  task automatic drv(input logic v, input logic fl,
                     input logic us, input logic [4:0] rs,
                     input logic ut, input logic [4:0] rt,
                     input logic rw, input logic [4:0] rd,
                     input logic mr);
    id_valid    = v;
    id_flush    = fl;
    id_use_rs   = us;
    id_rs       = rs;
    id_use_rt   = ut;
    id_rt       = rt;
    id_regwrite = rw;
    id_rd       = rd;
    id_memread  = mr;
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs,
                     input logic [1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(1, 0, 1, 5'd5, 0, 5'd0, 1, 5'd5, 1);
    @(posedge clk);
    #1;
    chk("rst_stall", {1'b0, stall}, 2'd0);
    chk("rst_issue", {1'b0, issue}, 2'd0);
    chk("rst_fwd_rs", fwd_rs, FWD_RF);
    tick;
    reset = 1'b0;

    // ALU chain: add $3, then beq $3,$4 at increasing distance
    drv(1, 0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 0);
    chk("add_issue", {1'b0, issue}, 2'd1);
    tick;
    drv(1, 0, 1, 5'd3, 1, 5'd4, 0, 5'd0, 0);
    chk("alu_stall", {1'b0, stall}, 2'd0);
    chk("alu_ex", fwd_rs, FWD_EX);
    chk("alu_rt_rf", fwd_rt, FWD_RF);
    tick;
    chk("alu_mem", fwd_rs, FWD_MEM);
    tick;
    chk("alu_wb", fwd_rs, FWD_WB);
    tick;
    chk("alu_done", fwd_rs, FWD_RF);
    tick;

    // load-use on rs and rt (rs == rt)
    drv(1, 0, 1, 5'd29, 0, 5'd0, 1, 5'd5, 1);
    chk("lw5_issue", {1'b0, issue}, 2'd1);
    tick;
    drv(1, 0, 1, 5'd5, 1, 5'd5, 1, 5'd6, 0);
    chk("lu_stall", {1'b0, stall}, 2'd1);
    chk("lu_issue", {1'b0, issue}, 2'd0);
    chk("lu_fwd_rs", fwd_rs, FWD_EX);
    chk("lu_fwd_rt", fwd_rt, FWD_EX);
    tick;
    chk("lu_stall2", {1'b0, stall}, 2'd0);
    chk("lu_issue2", {1'b0, issue}, 2'd1);
    chk("lu_rs_mem", fwd_rs, FWD_MEM);
    chk("lu_rt_mem", fwd_rt, FWD_MEM);
    tick;

    // load-use via rt only
    drv(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd10, 1);
    tick;
    drv(1, 0, 0, 5'd0, 1, 5'd10, 0, 5'd0, 0);
    chk("lurt_stall", {1'b0, stall}, 2'd1);
    tick;
    chk("lurt_stall2", {1'b0, stall}, 2'd0);
    chk("lurt_mem", fwd_rt, FWD_MEM);
    tick;

    // unused rt pointing at a pending load
    drv(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd11, 1);
    tick;
    drv(1, 0, 1, 5'd0, 0, 5'd11, 0, 5'd0, 0);
    chk("nouse_stall", {1'b0, stall}, 2'd0);
    chk("nouse_issue", {1'b0, issue}, 2'd1);
    chk("nouse_fwd", fwd_rt, FWD_RF);
    tick;

    // override: add $7 then lw $7, load is newest
    drv(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0);
    tick;
    drv(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 1);
    tick;
    drv(1, 0, 1, 5'd7, 0, 5'd0, 0, 5'd0, 0);
    chk("ovr_stall", {1'b0, stall}, 2'd1);
    tick;
    chk("ovr_stall2", {1'b0, stall}, 2'd0);
    chk("ovr_mem", fwd_rs, FWD_MEM);
    tick;

    // register zero
    drv(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd0, 1);
    tick;
    drv(1, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0);
    chk("r0_stall", {1'b0, stall}, 2'd0);
    chk("r0_fwd_rs", fwd_rs, FWD_RF);
    chk("r0_fwd_rt", fwd_rt, FWD_RF);
    tick;

    // flushed writer of $9
    drv(1, 1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 1);
    chk("fl_issue", {1'b0, issue}, 2'd0);
    chk("fl_stall", {1'b0, stall}, 2'd0);
    tick;
    drv(1, 0, 1, 5'd9, 0, 5'd0, 0, 5'd0, 0);
    chk("fl_fwd", fwd_rs, FWD_RF);
    tick;

    // invalid writer of $12
    drv(0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd12, 0);
    chk("inv_issue", {1'b0, issue}, 2'd0);
    tick;
    drv(1, 0, 1, 5'd12, 0, 5'd0, 0, 5'd0, 0);
    chk("inv_fwd", fwd_rs, FWD_RF);
    tick;

    // reset mid-flight drops a pending load
    drv(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd2, 1);
    chk("lw2_issue", {1'b0, issue}, 2'd1);
    tick;
    reset = 1'b1;
    drv(1, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0, 0);
    chk("mrst_stall", {1'b0, stall}, 2'd0);
    chk("mrst_issue", {1'b0, issue}, 2'd0);
    tick;
    reset = 1'b0;
    drv(1, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0, 0);
    chk("post_stall", {1'b0, stall}, 2'd0);
    chk("post_fwd", fwd_rs, FWD_RF);
    chk("post_issue", {1'b0, issue}, 2'd1);
    tick;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
